// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO mul/div unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, opA, opB, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, opA, opB, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, followed by a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  muldiv_unit_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  // MUL: {partial high, multiplier shifting out}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   opa_q;
  logic               is_div_q;
  logic               neg_q;
  logic               remneg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes for the accept edge; signed ops take |x|.
  always_comb begin
    sgn_op = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    a_mag  = (sgn_op && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    b_mag  = (sgn_op && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
  end

  // One iteration step for both algorithms.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? b_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    // Shifted remainder can exceed WIDTH bits only when the trial subtract succeeds,
    // so the restored path safely drops the top bit.
    if (div_trial[WIDTH])
      div_next = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction and special cases applied in the FIX cycle.
  always_comb begin
    prod_neg = -prod_q;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];
    fix_hi   = hi_q;
    fix_lo   = lo_q;
    if (!is_div_q) begin
      {fix_hi, fix_lo} = neg_q ? prod_neg : prod_q;
    end else if (dz_q) begin
      fix_hi = opa_q;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q ? -quo : quo;
      fix_hi = remneg_q ? -rem : rem;
    end
  end

  // Control FSM with registered busy/done and the HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      b_q      <= '0;
      opa_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      remneg_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.funct)
              F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                prod_q   <= {{WIDTH{1'b0}}, a_mag};
                b_q      <= b_mag;
                opa_q    <= bus.opA;
                neg_q    <= sgn_op && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                remneg_q <= sgn_op && bus.opA[WIDTH-1];
                dz_q     <= (bus.opB == '0);
                is_div_q <= bus.funct[1];
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= bus.funct[1] ? S_DIV : S_MUL;
              end
              F_MTHI:  hi_q <= bus.opA;
              F_MTLO:  lo_q <= bus.opA;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (bus.cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            prod_q <= (state_q == S_MUL) ? mul_next : div_next;
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!bus.cancel) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected HI/LO and accept
// cycle; a monitor compares on every done pulse, including the latency.
module tb_muldiv_unit;
  localparam int unsigned W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0 at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_hi"}, bus.hi, mon_e.hi);
        chk({mon_e.name, "_lo"}, bus.lo, mon_e.lo);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(W + 1));
      end
    end
  end

  // Drive one request at the current negedge; held for exactly one rising edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done, input logic [31:0] eh, input logic [31:0] el,
                       input string name);
    bus.start = 1'b1;
    bus.funct = f;
    bus.opA   = a;
    bus.opB   = b;
    if (expect_done) exp_q.push_back('{hi: eh, lo: el, acc: cyc + 1, name: name});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: actual=pending required=done", name);
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    bus.start  = 1'b0;
    bus.funct  = '0;
    bus.opA    = '0;
    bus.opB    = '0;
    bus.cancel = 1'b0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_hi",   bus.hi, 32'h0);
    chk("reset_lo",   bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(F_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    drain("mult_neg3x5");

    // A start while busy, with changed operands, must be ignored.
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.funct = F_DIVU; bus.opA = 32'd1; bus.opB = 32'd1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    chk("busy_during_multu", 32'(bus.busy), 32'd1);
    drain("multu_max");

    issue(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, "mult_min_neg1");
    drain("mult_min_neg1");
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    drain("div_neg7_2");
    issue(F_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2");
    drain("div_7_neg2");
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, "div_min_neg1");
    drain("div_min_neg1");
    issue(F_DIVU, 32'd10, 32'd0, 1'b1, 32'h0000_000A, 32'hFFFF_FFFF, "divu_10_0");
    drain("divu_10_0");
    issue(F_DIV, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg5_0");
    drain("div_neg5_0");

    // Back-to-back: second start issued in the done cycle of the first.
    issue(F_DIVU, 32'd100, 32'd7, 1'b1, 32'h0000_0002, 32'h0000_000E, "divu_100_7");
    n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 32'(bus.done), 32'd1);
    issue(F_MULTU, 32'd3, 32'd4, 1'b1, 32'h0000_0000, 32'h0000_000C, "b2b_multu_3x4");
    drain("b2b_multu_3x4");

    // MTLO then MTHI on consecutive cycles.
    issue(F_MTLO, 32'h0000_1234, 32'd0, 1'b0, '0, '0, "mtlo");
    chk("mtlo_lo",   bus.lo, 32'h0000_1234);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    issue(F_MTHI, 32'h0000_ABCD, 32'd0, 1'b0, '0, '0, "mthi");
    chk("mthi_hi",   bus.hi, 32'h0000_ABCD);
    chk("mthi_lo",   bus.lo, 32'h0000_1234);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_done", 32'(bus.done), 32'd0);

    // cancel in IDLE beats start, even for MTHI.
    bus.cancel = 1'b1;
    issue(F_MTHI, 32'h5555_5555, 32'd0, 1'b0, '0, '0, "mthi_cancelled");
    bus.cancel = 1'b0;
    chk("cancel_idle_hi",   bus.hi, 32'h0000_ABCD);
    chk("cancel_idle_busy", 32'(bus.busy), 32'd0);

    // Cancel seen at iteration edge E10.
    issue(F_MULTU, 32'd3, 32'd4, 1'b0, '0, '0, "multu_cancel");
    repeat (9) @(negedge clk);
    chk("cancel_busy_before", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy_after", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_hi", bus.hi, 32'h0000_ABCD);
    chk("cancel_lo", bus.lo, 32'h0000_1234);

    // Asynchronous reset in the middle of a divide.
    issue(F_DIV, 32'd100, 32'd3, 1'b0, '0, '0, "div_reset");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_done", 32'(bus.done), 32'd0);
    chk("midreset_hi",   bus.hi, 32'h0);
    chk("midreset_lo",   bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(F_MULTU, 32'd2, 32'd3, 1'b1, 32'h0000_0000, 32'h0000_0006, "post_reset_multu");
    drain("post_reset_multu");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the HI/LO register pair. It sits beside the single-cycle ALU in the execute stage and is driven by the same SPECIAL funct codes. It accepts MULT/MULTU/DIV/DIVU and runs them over WIDTH+1 cycles behind a busy/done handshake. MTHI/MTLO take one cycle; MFHI/MFLO are served combinationally from the HI/LO outputs. Width is parametrised, and a cancel input supports pipeline flush.

## Interface
- WIDTH, 32: operand, HI and LO width; must be ≥ 4 and even.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at the rising edge of clk
- funct  input  6  SPECIAL funct code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
- opA  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source)
- opB  input  WIDTH  rt value (multiplier/divisor)
- cancel  input  1  abort the in-flight operation (flush)
- busy  output  1  unit occupied; the pipeline stalls MF*/MT*/mul/div on it
- done  output  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset (async, rst_n low): state IDLE; busy=0, done=0, hi=0, lo=0; iteration counter 0.
- In IDLE with start=1 and cancel=0, funct decodes as follows:
  - MULT/MULTU: latch operands and enter MUL.
  - DIV/DIVU: latch operands and enter DIV.
  - MTHI: hi←opA at that edge; stay IDLE; busy stays 0; done stays 0.
  - MTLO: lo←opA at that edge; same rules as MTHI.
  - Any other funct: ignored; no state change and no warning output.
- Signed ops (MULT/DIV) work on magnitudes. The sign flags are latched at accept time.
- MUL: shift-add, one multiplier bit per cycle, over WIDTH cycles. The 2·WIDTH product accumulates internally.
- DIV: restoring division, one quotient bit per cycle, over WIDTH cycles.
- FIX: one cycle. It applies sign correction and writes the results:
  - Multiply: {hi,lo} ← product, negated (two's complement over 2·WIDTH) if the operand signs differ.
  - Divide: lo ← quotient, negated if the operand signs differ. hi ← remainder, with the sign of the dividend.
  - Most-negative ÷ −1: lo ← most-negative, hi ← 0 (natural wrap, no trap).
  - Divide by zero (DIV or DIVU): hi ← opA, lo ← all-ones. The iteration still runs its full length and is not shortened.
  - After the write, the state returns to IDLE.
- start while busy=1 is ignored; the pipeline must hold the request.
- cancel=1 in MUL/DIV/FIX: return to IDLE at that edge. hi/lo keep their pre-operation values, and done is not asserted.
- cancel=1 in IDLE has priority over start in the same cycle; the start is dropped, including MTHI/MTLO.
- Operands are captured at accept. Later changes on opA/opB have no effect.

## Timing
- Accept edge E0. busy is 1 from the cycle after E0 up to and including the cycle ending at edge E(WIDTH+1).
- Iteration edges are E1..E(WIDTH). FIX writes hi/lo at E(WIDTH+1).
- After E(WIDTH+1), busy=0 and done=1 for exactly one cycle. The new hi/lo are visible in that same cycle.
- Latency from start to done is therefore WIDTH+1 cycles (33 when WIDTH=32).
- A new start is allowed in the done cycle; it is accepted normally.
- MTHI/MTLO: the value is visible on hi/lo in the cycle after the edge.
- Outputs hi, lo, busy and done are all registered. There is no combinational path from inputs to outputs.
- rst_n asserted mid-operation: everything clears immediately (async). The first accept is possible at the first edge after release.

## Test plan
- MULT opA=0xFFFFFFFD (−3), opB=5 → after 33 cycles: done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. A start issued while busy during this op is ignored, and the result is unchanged.
- Divide signs and edge cases:
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 10/0 → hi=0x0000000A, lo=0xFFFFFFFF, latency still 33 cycles.
- MTLO 0x1234 followed by MTHI 0xABCD on consecutive cycles → lo=0x1234, hi=0xABCD; busy never asserts and done never pulses.
- Abort and reset:
  - MULTU 3×4, then cancel at iteration 10 → busy=0 the next cycle, no done, hi/lo keep their prior values.
  - Separately, rst_n low mid-DIV → all outputs 0 immediately.
  - A back-to-back start in the done cycle is accepted.
